sdram_to_uart: RTL and testbench
================================

Name: sdram_to_uart

Overview:
- Return path of the UART/SDRAM bridge: takes SDRAM read data words and write-completion events from the controller side and serializes them into a byte stream for the UART transmitter.
- Each read word is sent as a 3-byte frame: ASCII "D" (0x44), data[15:8], data[7:0].
- Each write completion is sent as a single ASCII "K" (0x4B).
- A small event FIFO decouples the controller from the slower UART so back-to-back completions are not lost.

Parameters:
- AW, 2, FIFO address width; FIFO depth DEPTH = 2**AW entries (default 4).
- HDR_RD, 8'h44, header byte for read-data frames.
- HDR_WT, 8'h4B, byte sent for write completion.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- rd_data  input  16  SDRAM read word, valid while rd_stb high.
- rd_stb  input  1  read word available.
- rd_ack  output  1  read word accepted this cycle.
- wt_stb  input  1  write operation completed.
- wt_ack  output  1  write completion accepted this cycle.
- o_data  output  8  byte to UART TX.
- o_stb  output  1  o_data valid.
- o_ack  input  1  UART TX has taken o_data this cycle.
- busy  output  1  FIFO non-empty or frame in progress.

Behaviour:
- Handshake (all ports): a transfer occurs on a rising edge where stb and ack are both high. A source holds stb and data stable until acked.
- Reset (RST_N low, async): FIFO empty, pointers and count 0, FSM IDLE, o_stb=0, o_data=0, busy=0, rd_ack=0, wt_ack=0. A frame in progress is discarded with no partial bytes afterwards.
- FIFO entry format: 17 bits = {type, word}. type 0 = read data; type 1 = write completion, word ignored and stored as 0.
- FIFO uses write pointer, read pointer and count (AW+1 bits). Pointers wrap modulo DEPTH.
- Push rules (combinational acks, both gated by RST_N):
  - rd_ack = rd_stb & !full.
  - wt_ack = wt_stb & !rd_stb & !full. Read has priority; a simultaneous wt_stb waits at least one cycle.
  - At most one push per cycle.
  - full means count==DEPTH. No push while full, even if a pop occurs the same cycle.
- Pop happens on the edge where the last byte of the head frame is acked. A simultaneous push and pop leaves count unchanged.
- TX FSM states:
  - IDLE: o_stb=0. If count!=0, go to HDR on the next edge.
  - HDR: o_stb=1. o_data=HDR_RD for type 0, HDR_WT for type 1. On o_ack: type 0 goes to DATA_HI; type 1 pops and goes to IDLE.
  - DATA_HI: o_stb=1, o_data=head word[15:8]. On o_ack go to DATA_LO.
  - DATA_LO: o_stb=1, o_data=head word[7:0]. On o_ack pop and go to IDLE.
- o_data is driven from the FSM state and the FIFO head. The head is stable until pop, so o_data is stable while o_stb is high.
- Latency: o_stb rises one cycle after the edge that pushes into an empty FIFO. With o_ack held high, a read frame takes 3 cycles, then one IDLE cycle before the next frame.
- Frame ordering equals acceptance order. Bytes of different frames never interleave.
- busy = (count!=0) | (state!=IDLE).
- Empty FIFO in IDLE: outputs stay quiet, no spurious o_stb.

Test Plan:
- Reset then rd_data=16'hA5C3, rd_stb pulse, o_ack tied high -> rd_ack high for 1 cycle; o_data sequence 0x44, 0xA5, 0xC3 on consecutive o_stb cycles; busy returns to 0.
- wt_stb single pulse, o_ack high -> single byte 0x4B, FIFO empty afterwards.
- rd_stb and wt_stb both high, same cycle, rd_data=16'h1234 -> read accepted first, write accepted next cycle; output 0x44,0x12,0x34,0x4B.
- o_ack held low, 5 read words offered (0x0001..0x0005) -> first 4 accepted, rd_ack low for the 5th while full. Release o_ack -> after first pop the 5th word is accepted; all 15 bytes emerge in order.
- Random o_ack stalls during a frame with rd_data=16'hBEEF -> o_data holds each byte stable while o_stb=1 and o_ack=0; sequence 0x44,0xBE,0xEF unbroken.
- RST_N asserted low while in DATA_HI with 2 entries queued -> o_stb drops immediately, count=0. After release no bytes are emitted until new input.

Source files
------------

// File: rtl/sdram_to_uart_if.sv
// Handshake bundle between the SDRAM controller side, the bridge and the UART TX.
// The bridge takes the master modport; the environment around it takes slave.
interface sdram_to_uart_if;
  logic [15:0] rd_data;
  logic        rd_stb;
  logic        rd_ack;
  logic        wt_stb;
  logic        wt_ack;
  logic [7:0]  o_data;
  logic        o_stb;
  logic        o_ack;
  logic        busy;

  modport master (
    input  rd_data, rd_stb, wt_stb, o_ack,
    output rd_ack, wt_ack, o_data, o_stb, busy
  );

  modport slave (
    output rd_data, rd_stb, wt_stb, o_ack,
    input  rd_ack, wt_ack, o_data, o_stb, busy
  );
endinterface

// File: rtl/sdram_to_uart.sv
// Return path of the UART/SDRAM bridge. Read words and write completions are
// queued in a small event FIFO and serialized into UART bytes:
//   read word        -> HDR_RD, word[15:8], word[7:0]
//   write completion -> HDR_WT
module sdram_to_uart #(
  parameter int          AW     = 2,
  parameter logic [7:0]  HDR_RD = 8'h44,
  parameter logic [7:0]  HDR_WT = 8'h4B
) (
  input  logic            CLK,
  input  logic            RST_N,
  sdram_to_uart_if.master bus
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, HDR, DATA_HI, DATA_LO} state_t;

  state_t state_reg, state_next;

  // FIFO entry: {type, word}; type 1 marks a write completion (word stored as 0)
  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  logic          full;
  logic          push;
  logic          pop;
  logic [16:0]   push_entry;
  logic [16:0]   head;
  logic          head_type;
  logic [15:0]   head_word;

  assign full      = (count_reg == (AW + 1)'(DEPTH));
  assign head      = mem[rd_ptr_reg];
  assign head_type = head[16];
  assign head_word = head[15:0];

  // Read has priority over write completion; at most one push per cycle.
  // A pop in the same cycle does not free a slot for a push while full.
  assign bus.rd_ack = RST_N & bus.rd_stb & ~full;
  assign bus.wt_ack = RST_N & bus.wt_stb & ~bus.rd_stb & ~full;
  assign push       = bus.rd_ack | bus.wt_ack;
  assign push_entry = bus.rd_ack ? {1'b0, bus.rd_data} : {1'b1, 16'h0000};

  assign bus.busy = (count_reg != '0) | (state_reg != IDLE);

  // FIFO storage write; no reset needed since count gates what is visible
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // TX state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // TX next state and byte outputs; head is stable until pop so o_data is too
  always_comb begin
    state_next = state_reg;
    bus.o_stb  = 1'b0;
    bus.o_data = 8'h00;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          state_next = HDR;
        end
      end
      HDR: begin
        bus.o_stb  = 1'b1;
        bus.o_data = head_type ? HDR_WT : HDR_RD;
        if (bus.o_ack) begin
          if (head_type) begin
            pop        = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        bus.o_stb  = 1'b1;
        bus.o_data = head_word[15:8];
        if (bus.o_ack) begin
          state_next = DATA_LO;
        end
      end
      DATA_LO: begin
        bus.o_stb  = 1'b1;
        bus.o_data = head_word[7:0];
        if (bus.o_ack) begin
          pop        = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_to_uart.sv
// Bench for sdram_to_uart: directed scenarios followed by random traffic,
// checked against a frame-level model (byte queue plus per-frame byte counts).
module tb_sdram_to_uart;

  localparam int DEPTH = 4;

  logic CLK;
  logic RST_N;

  sdram_to_uart_if bus ();

  sdram_to_uart #(.AW(2), .HDR_RD(8'h44), .HDR_WT(8'h4B)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         occ = 0;         // frames accepted and not yet fully sent
  logic [7:0] byteq[$];        // every byte still owed, in order
  int         frame_left[$];   // bytes remaining for each queued frame
  int         idle_run = 0;    // cycles with work pending but no o_stb
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    occ = 0;
    byteq.delete();
    frame_left.delete();
    idle_run = 0;
    prev_stall = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model for the coming
  // rising edge, then release any strobe that was accepted.
  task automatic cycle();
    logic exp_rd, exp_wt;
    int   popped;
    @(negedge CLK);
    exp_rd = bus.rd_stb && (occ < DEPTH);
    exp_wt = bus.wt_stb && !bus.rd_stb && (occ < DEPTH);
    popped = 0;
    chk("rd_ack", {31'b0, bus.rd_ack}, {31'b0, exp_rd});
    chk("wt_ack", {31'b0, bus.wt_ack}, {31'b0, exp_wt});
    chk("busy", {31'b0, bus.busy}, {31'b0, (occ != 0)});
    if (prev_stall) begin
      chk("hold_stb", {31'b0, bus.o_stb}, 32'd1);
      chk("hold_data", {24'b0, bus.o_data}, {24'b0, prev_data});
    end
    if (bus.o_stb) begin
      idle_run = 0;
      if (byteq.size() == 0) chk("spurious_stb", {31'b0, bus.o_stb}, 32'd0);
      else chk("o_data", {24'b0, bus.o_data}, {24'b0, byteq[0]});
    end else if (occ != 0) begin
      idle_run++;
      chk("idle_gap", {31'b0, (idle_run > 1)}, 32'd0);
    end else begin
      idle_run = 0;
    end
    if (bus.o_stb && bus.o_ack && byteq.size() > 0) begin
      void'(byteq.pop_front());
      frame_left[0] = frame_left[0] - 1;
      if (frame_left[0] == 0) begin
        void'(frame_left.pop_front());
        popped = 1;
      end
    end
    if (exp_rd) begin
      byteq.push_back(8'h44);
      byteq.push_back(bus.rd_data[15:8]);
      byteq.push_back(bus.rd_data[7:0]);
      frame_left.push_back(3);
    end
    if (exp_wt) begin
      byteq.push_back(8'h4B);
      frame_left.push_back(1);
    end
    occ = occ + ((exp_rd || exp_wt) ? 1 : 0) - popped;
    prev_stall = bus.o_stb && !bus.o_ack;
    prev_data  = bus.o_data;
    @(posedge CLK);
    #1;
    if (exp_rd) bus.rd_stb = 1'b0;
    if (exp_wt) bus.wt_stb = 1'b0;
  endtask

  task automatic send_rd(input logic [15:0] w);
    int n;
    bus.rd_data = w;
    bus.rd_stb  = 1'b1;
    n = 0;
    while (bus.rd_stb && n < 100) begin
      cycle();
      n++;
    end
    chk("send_rd_timeout", {31'b0, bus.rd_stb}, 32'd0);
  endtask

  // Run until everything offered has been sent; o_ack random if rand_ack set.
  task automatic drain(input bit rand_ack);
    int n;
    n = 0;
    while ((occ != 0 || bus.rd_stb || bus.wt_stb) && n < 500) begin
      bus.o_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      n++;
    end
    chk("drain_done", {31'b0, (occ == 0 && !bus.rd_stb && !bus.wt_stb)}, 32'd1);
    chk("drain_queue", byteq.size(), 32'd0);
    bus.o_ack = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_o_stb"}, {31'b0, bus.o_stb}, 32'd0);
    chk({tag, "_o_data"}, {24'b0, bus.o_data}, 32'd0);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_rd_ack"}, {31'b0, bus.rd_ack}, 32'd0);
    chk({tag, "_wt_ack"}, {31'b0, bus.wt_ack}, 32'd0);
  endtask

  initial begin
    int n;
    RST_N       = 1'b0;
    bus.rd_data = 16'h0000;
    bus.rd_stb  = 1'b1;
    bus.wt_stb  = 1'b1;
    bus.o_ack   = 1'b1;
    #2;
    check_reset_outputs("reset");
    bus.rd_stb = 1'b0;
    bus.wt_stb = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_clear();
    repeat (3) cycle();

    // single read frame
    send_rd(16'hA5C3);
    drain(1'b0);

    // single write completion
    bus.wt_stb = 1'b1;
    drain(1'b0);

    // simultaneous read and write: read first, write one cycle later
    bus.rd_data = 16'h1234;
    bus.rd_stb  = 1'b1;
    bus.wt_stb  = 1'b1;
    drain(1'b0);

    // fill the FIFO while the UART is stalled, fifth word must wait
    bus.o_ack = 1'b0;
    for (int i = 1; i <= 4; i++) send_rd(16'(i));
    bus.rd_data = 16'h0005;
    bus.rd_stb  = 1'b1;
    repeat (3) cycle();
    chk("full_holds_5th", {31'b0, bus.rd_stb}, 32'd1);
    drain(1'b0);

    // random stalls inside a frame
    bus.rd_data = 16'hBEEF;
    bus.rd_stb  = 1'b1;
    drain(1'b1);

    // reset in the middle of a frame with two entries queued
    bus.o_ack = 1'b0;
    send_rd(16'h1111);
    send_rd(16'h2222);
    bus.o_ack = 1'b1;
    n = 0;
    while (byteq.size() > 5 && n < 20) begin
      cycle();
      n++;
    end
    bus.o_ack = 1'b0;
    cycle();
    chk("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    RST_N     = 1'b1;
    bus.o_ack = 1'b1;
    repeat (8) cycle();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if (!bus.rd_stb && $urandom_range(0, 3) == 0) begin
        bus.rd_stb  = 1'b1;
        bus.rd_data = 16'($urandom);
      end
      if (!bus.wt_stb && $urandom_range(0, 4) == 0) bus.wt_stb = 1'b1;
      bus.o_ack = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
